// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter that shares the single L1.5 NoC request port between the
// I-cache, D-cache load and write-buffer requesters, with a TID pool and a cap on outstanding stores.
module l15_req_arbiter #(
    parameter int NR_PORTS = 3,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int TID_W    = 2,
    parameter int MAX_ST   = 7
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NR_PORTS-1:0]          req_valid_i,
    output logic [NR_PORTS-1:0]          req_ready_o,
    input  logic [NR_PORTS-1:0]          req_store_i,
    input  logic [NR_PORTS*ADDR_W-1:0]   req_addr_i,
    input  logic [NR_PORTS*DATA_W-1:0]   req_wdata_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [DATA_W-1:0]            mem_req_wdata_o,
    output logic                         mem_req_store_o,
    output logic [TID_W-1:0]             mem_req_tid_o,
    output logic [1:0]                   mem_req_port_o,
    input  logic                         mem_rtrn_valid_i,
    input  logic [TID_W-1:0]             mem_rtrn_tid_i,
    output logic [NR_PORTS-1:0]          rtrn_valid_o,
    output logic                         spurious_o,
    output logic [3:0]                   st_cnt_o,
    output logic                         idle_o
);

    localparam int NTID = 1 << TID_W;

    logic [NTID-1:0]     r_free;
    logic [NTID-1:0]     r_st_bit;
    logic [1:0]          r_owner [NTID];
    logic [1:0]          r_rr;
    logic [3:0]          r_st_cnt;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_store;
    logic [TID_W-1:0]    r_tid;
    logic [1:0]          r_port;

    logic                w_can_load;
    logic                w_st_ok;
    logic [NR_PORTS-1:0] w_elig;
    logic                w_gnt_vld;
    logic [1:0]          w_gnt_idx;
    logic [TID_W-1:0]    w_alloc_tid;
    logic                w_rtrn_busy;
    logic                w_st_inc;
    logic                w_st_dec;

    assign w_can_load = ~r_valid | mem_req_ready_i;
    assign w_st_ok    = r_st_cnt < 4'(MAX_ST);

    always_comb begin
        for (int i = 0; i < NR_PORTS; i++) begin
            w_elig[i] = req_valid_i[i] & (|r_free) & (~req_store_i[i] | w_st_ok);
        end
    end

    // Search starts at the RR pointer so a blocked port never starves the others.
    always_comb begin : gnt_sel
        int p;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        p         = 0;
        for (int k = 0; k < NR_PORTS; k++) begin
            p = (int'(r_rr) + k) % NR_PORTS;
            if (!w_gnt_vld && w_can_load && w_elig[p]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = 2'(p);
            end
        end
    end

    // Allocation looks only at the registered mask, so a TID freed this cycle is not reused yet.
    always_comb begin
        w_alloc_tid = '0;
        for (int t = NTID - 1; t >= 0; t--) begin
            if (r_free[t]) w_alloc_tid = TID_W'(t);
        end
    end

    assign req_ready_o  = w_gnt_vld ? (NR_PORTS'(1) << w_gnt_idx) : '0;
    assign w_rtrn_busy  = mem_rtrn_valid_i & ~r_free[mem_rtrn_tid_i];
    assign rtrn_valid_o = w_rtrn_busy ? (NR_PORTS'(1) << r_owner[mem_rtrn_tid_i]) : '0;
    assign spurious_o   = mem_rtrn_valid_i & r_free[mem_rtrn_tid_i];
    assign w_st_inc     = w_gnt_vld & req_store_i[w_gnt_idx];
    assign w_st_dec     = w_rtrn_busy & r_st_bit[mem_rtrn_tid_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_free   <= '1;
            r_st_bit <= '0;
            for (int t = 0; t < NTID; t++) r_owner[t] <= '0;
            r_rr     <= '0;
            r_st_cnt <= '0;
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_store  <= 1'b0;
            r_tid    <= '0;
            r_port   <= '0;
        end else begin
            if (w_rtrn_busy) r_free[mem_rtrn_tid_i] <= 1'b1;
            if (w_gnt_vld) begin
                r_free[w_alloc_tid]   <= 1'b0;
                r_owner[w_alloc_tid]  <= w_gnt_idx;
                r_st_bit[w_alloc_tid] <= req_store_i[w_gnt_idx];
                r_rr    <= (int'(w_gnt_idx) == NR_PORTS - 1) ? 2'd0 : w_gnt_idx + 2'd1;
                r_valid <= 1'b1;
                r_addr  <= req_addr_i[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
                r_wdata <= req_wdata_i[int'(w_gnt_idx)*DATA_W +: DATA_W];
                r_store <= req_store_i[w_gnt_idx];
                r_tid   <= w_alloc_tid;
                r_port  <= w_gnt_idx;
            end else if (w_can_load) begin
                r_valid <= 1'b0;
            end
            if (w_st_inc && !w_st_dec) begin
                r_st_cnt <= r_st_cnt + 4'd1;
            end else if (w_st_dec && !w_st_inc) begin
                r_st_cnt <= r_st_cnt - 4'd1;
            end
        end
    end

    assign mem_req_valid_o = r_valid;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_wdata_o = r_wdata;
    assign mem_req_store_o = r_store;
    assign mem_req_tid_o   = r_tid;
    assign mem_req_port_o  = r_port;
    assign st_cnt_o        = r_st_cnt;
    assign idle_o          = (&r_free) & ~r_valid;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Randomized bench for l15_req_arbiter against a transaction-level model of the
// TID pool, store count, round-robin order and held NoC request.
module tb_l15_req_arbiter;

    localparam int NP   = 3;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int TW   = 3;
    localparam int NT   = 8;
    localparam int MAXS = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     req_store = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*DW-1:0]  req_wdata = '0;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [AW-1:0]     mem_req_addr;
    logic [DW-1:0]     mem_req_wdata;
    logic              mem_req_store;
    logic [TW-1:0]     mem_req_tid;
    logic [1:0]        mem_req_port;
    logic              mem_rtrn_valid = 1'b0;
    logic [TW-1:0]     mem_rtrn_tid = '0;
    logic [NP-1:0]     rtrn_valid;
    logic              spurious;
    logic [3:0]        st_cnt;
    logic              idle;

    always #5 clk = ~clk;

    l15_req_arbiter #(
        .NR_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TID_W(TW), .MAX_ST(MAXS)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o(mem_req_addr), .mem_req_wdata_o(mem_req_wdata),
        .mem_req_store_o(mem_req_store), .mem_req_tid_o(mem_req_tid),
        .mem_req_port_o(mem_req_port),
        .mem_rtrn_valid_i(mem_rtrn_valid), .mem_rtrn_tid_i(mem_rtrn_tid),
        .rtrn_valid_o(rtrn_valid), .spurious_o(spurious),
        .st_cnt_o(st_cnt), .idle_o(idle)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_busy  [NT];
    int          m_owner [NT];
    bit          m_isst  [NT];
    int          m_rr;
    int          m_st;
    bit          h_vld;
    logic [63:0] h_addr, h_data;
    bit          h_st;
    int          h_tid, h_port;

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_busy[t] = 0; m_owner[t] = 0; m_isst[t] = 0;
        end
        m_rr = 0; m_st = 0;
        h_vld = 0; h_addr = '0; h_data = '0; h_st = 0; h_tid = 0; h_port = 0;
    endtask

    initial begin
        int   gnt, alloc, nbusy, exp_rtrn, exp_spur, p;
        bit   can_load, rtrn_hit;
        int   busy_q[$];

        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = (cyc < 2) || (cyc > 400 && $urandom_range(0, 299) == 0);
            busy_q.delete();
            for (int t = 0; t < NT; t++) if (m_busy[t]) busy_q.push_back(t);
            for (int i = 0; i < NP; i++) begin
                req_addr[i*AW +: AW]  = {$urandom, $urandom};
                req_wdata[i*DW +: DW] = {$urandom, $urandom};
            end
            if (rst) begin
                req_valid = '0; req_store = '0; mem_req_ready = 1'b0;
                mem_rtrn_valid = 1'b0; mem_rtrn_tid = '0;
            end else if (cyc < 40) begin
                // every port loads, NoC always ready, nothing returns: pool drains
                req_valid = '1; req_store = '0; mem_req_ready = 1'b1;
                mem_rtrn_valid = 1'b0; mem_rtrn_tid = '0;
            end else if (cyc < 400) begin
                // write buffer streams stores, returns are rare: store cap gets hit
                req_valid = {1'b1, 2'($urandom)};
                req_store = 3'b100;
                mem_req_ready = ($urandom_range(0, 3) != 0);
                mem_rtrn_valid = (busy_q.size() > 0) && ($urandom_range(0, 9) == 0);
                mem_rtrn_tid = mem_rtrn_valid ? TW'(busy_q[$urandom_range(0, busy_q.size()-1)]) : '0;
            end else begin
                req_valid = 3'($urandom);
                req_store = 3'($urandom);
                mem_req_ready = ($urandom_range(0, 2) != 0);
                mem_rtrn_valid = ($urandom_range(0, 2) == 0);
                if (busy_q.size() > 0 && $urandom_range(0, 4) != 0)
                    mem_rtrn_tid = TW'(busy_q[$urandom_range(0, busy_q.size()-1)]);
                else
                    mem_rtrn_tid = TW'($urandom_range(0, NT-1));
            end
            #1;

            gnt = -1; alloc = -1; rtrn_hit = 0;
            if (!rst) begin
                nbusy = busy_q.size();
                can_load = !h_vld || mem_req_ready;
                if (can_load && nbusy < NT) begin
                    for (int k = 0; k < NP; k++) begin
                        p = (m_rr + k) % NP;
                        if (gnt < 0 && req_valid[p] && (!req_store[p] || m_st < MAXS)) gnt = p;
                    end
                end
                for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) alloc = t;
                exp_rtrn = 0; exp_spur = 0;
                if (mem_rtrn_valid) begin
                    if (m_busy[mem_rtrn_tid]) begin
                        rtrn_hit = 1;
                        exp_rtrn = 1 << m_owner[mem_rtrn_tid];
                    end else begin
                        exp_spur = 1;
                    end
                end
                check_val("req_ready",  64'(req_ready),  64'((gnt >= 0) ? (1 << gnt) : 0));
                check_val("rtrn_valid", 64'(rtrn_valid), 64'(exp_rtrn));
                check_val("spurious",   64'(spurious),   64'(exp_spur));
                check_val("st_cnt",     64'(st_cnt),     64'(m_st));
                check_val("idle",       64'(idle),       64'((nbusy == 0 && !h_vld) ? 1 : 0));
                check_val("mem_valid",  64'(mem_req_valid), 64'(h_vld));
                if (h_vld) begin
                    check_val("mem_addr",  mem_req_addr,  h_addr);
                    check_val("mem_wdata", mem_req_wdata, h_data);
                    check_val("mem_store", 64'(mem_req_store), 64'(h_st));
                    check_val("mem_tid",   64'(mem_req_tid),   64'(h_tid));
                    check_val("mem_port",  64'(mem_req_port),  64'(h_port));
                end
            end

            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                if (rtrn_hit) begin
                    m_busy[mem_rtrn_tid] = 0;
                    if (m_isst[mem_rtrn_tid]) m_st--;
                end
                if (gnt >= 0) begin
                    m_busy[alloc]  = 1;
                    m_owner[alloc] = gnt;
                    m_isst[alloc]  = req_store[gnt];
                    if (req_store[gnt]) m_st++;
                    m_rr   = (gnt + 1) % NP;
                    h_vld  = 1;
                    h_addr = req_addr[gnt*AW +: AW];
                    h_data = req_wdata[gnt*DW +: DW];
                    h_st   = req_store[gnt];
                    h_tid  = alloc;
                    h_port = gnt;
                end else if (!h_vld || mem_req_ready) begin
                    h_vld = 0;
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
